// File: rtl/dma_strided_req_gen_if.sv
// Request-generator bus: DMA start command, local dmem FIFO head, and endpoint request/response.
// The master modport is the generator side and the slave modport is the environment side.
interface dma_strided_req_gen_if #(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 32,
  parameter int len_width_p    = 12,
  parameter int reg_id_width_p = 5
);
  logic                        start_v_i;
  logic                        start_ready_o;
  logic                        push_not_pull_i;
  logic [addr_width_p-1:0]     base_addr_i;
  logic [addr_width_p-1:0]     stride_i;
  logic [len_width_p-1:0]      num_words_i;
  logic [reg_id_width_p-1:0]   reg_id_i;

  logic [data_width_p-1:0]     push_data_i;
  logic                        push_v_i;
  logic                        push_yumi_o;

  logic                        req_v_o;
  logic                        req_ready_i;
  logic                        req_write_not_read_o;
  logic [addr_width_p-1:0]     req_addr_o;
  logic [data_width_p-1:0]     req_data_o;
  logic [data_width_p/8-1:0]   req_mask_o;
  logic [reg_id_width_p-1:0]   req_reg_id_o;
  logic                        resp_v_i;

  logic                        busy_o;
  logic                        done_o;

  modport master (
    input  start_v_i, push_not_pull_i, base_addr_i, stride_i, num_words_i, reg_id_i,
    input  push_data_i, push_v_i, req_ready_i, resp_v_i,
    output start_ready_o, push_yumi_o, req_v_o, req_write_not_read_o, req_addr_o,
    output req_data_o, req_mask_o, req_reg_id_o, busy_o, done_o
  );

  modport slave (
    output start_v_i, push_not_pull_i, base_addr_i, stride_i, num_words_i, reg_id_i,
    output push_data_i, push_v_i, req_ready_i, resp_v_i,
    input  start_ready_o, push_yumi_o, req_v_o, req_write_not_read_o, req_addr_o,
    input  req_data_o, req_mask_o, req_reg_id_o, busy_o, done_o
  );
endinterface

// File: rtl/dma_strided_req_gen.sv
// Strided remote load/store request generator with credit-bounded outstanding requests.
// Completion is reported only once every issued request has been answered.
module dma_strided_req_gen #(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 32,
  parameter int len_width_p    = 12,
  parameter int max_out_p      = 4,
  parameter int reg_id_width_p = 5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  dma_strided_req_gen_if.master bus
);

  localparam int credit_width_lp = $clog2(max_out_p + 1);
  localparam logic [credit_width_lp-1:0] max_out_lp = credit_width_lp'(max_out_p);
  localparam logic [credit_width_lp-1:0] one_credit_lp = credit_width_lp'(1);

  typedef enum logic [1:0] {IDLE, PUSH, PULL, DRAIN} state_e;

  state_e                      state_reg, state_next;
  logic [addr_width_p-1:0]     cursor_reg;
  logic [addr_width_p-1:0]     stride_reg;
  logic [len_width_p-1:0]      remaining_reg;
  logic [reg_id_width_p-1:0]   reg_id_reg;
  logic [credit_width_lp-1:0]  outstanding_reg, outstanding_next;

  logic                        credit_ok;
  logic                        fire;
  logic                        drained;
  logic                        start_ready;
  logic                        req_v;
  logic                        write_not_read;
  logic [data_width_p-1:0]     req_data;
  logic                        push_yumi;
  logic                        busy;
  logic                        done;

  assign credit_ok = (outstanding_reg < max_out_lp);
  assign fire      = req_v & bus.req_ready_i;
  // A response landing this cycle on the last outstanding request still counts as drained.
  assign drained   = (outstanding_reg == '0) | ((outstanding_reg == one_credit_lp) & bus.resp_v_i);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.start_v_i) begin
          if (bus.num_words_i == '0)     state_next = DRAIN;
          else if (bus.push_not_pull_i)  state_next = PUSH;
          else                           state_next = PULL;
        end
      end
      PUSH, PULL: begin
        if (fire && (remaining_reg == len_width_p'(1))) state_next = DRAIN;
      end
      DRAIN: begin
        if (drained) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic; req_v never looks at req_ready_i
  always_comb begin
    start_ready    = 1'b0;
    req_v          = 1'b0;
    write_not_read = 1'b0;
    req_data       = '0;
    push_yumi      = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    unique case (state_reg)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      PUSH: begin
        req_v          = bus.push_v_i & credit_ok;
        write_not_read = 1'b1;
        req_data       = bus.push_data_i;
        push_yumi      = bus.push_v_i & credit_ok & bus.req_ready_i;
      end
      PULL: begin
        req_v = credit_ok;
      end
      DRAIN: begin
        done = drained;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Credit counter: simultaneous issue and return cancel out
  always_comb begin
    outstanding_next = outstanding_reg;
    if (fire && !bus.resp_v_i)
      outstanding_next = outstanding_reg + one_credit_lp;
    else if (!fire && bus.resp_v_i && (outstanding_reg != '0))
      outstanding_next = outstanding_reg - one_credit_lp;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cursor_reg      <= '0;
      stride_reg      <= '0;
      remaining_reg   <= '0;
      reg_id_reg      <= '0;
      outstanding_reg <= '0;
    end else begin
      if ((state_reg == IDLE) && bus.start_v_i) begin
        cursor_reg    <= bus.base_addr_i;
        stride_reg    <= bus.stride_i;
        remaining_reg <= bus.num_words_i;
        reg_id_reg    <= bus.reg_id_i;
      end else if (fire) begin
        cursor_reg    <= cursor_reg + stride_reg;
        remaining_reg <= remaining_reg - len_width_p'(1);
      end
      outstanding_reg <= outstanding_next;
    end
  end

  assign bus.start_ready_o        = start_ready;
  assign bus.req_v_o              = req_v;
  assign bus.req_write_not_read_o = write_not_read;
  assign bus.req_addr_o           = cursor_reg;
  assign bus.req_data_o           = req_data;
  assign bus.req_mask_o           = '1;
  assign bus.req_reg_id_o         = reg_id_reg;
  assign bus.push_yumi_o          = push_yumi;
  assign bus.busy_o               = busy;
  assign bus.done_o               = done;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (fire)
        $display("%m: %s addr=%h data=%h", write_not_read ? "store" : "load", cursor_reg, req_data);
      if (bus.resp_v_i && (outstanding_reg == '0))
        $display("%m: resp_v_i with no outstanding request ignored");
    end
  end
`endif

endmodule
